cache_bus_arbiter: RTL and testbench
====================================

# cache_bus_arbiter

Shares the single cache-to-bus port (rd/ret/wr handshake toward the AXI bridge) between the ICache refill path and the DCache refill/writeback path. Holds one outstanding read, routes returned beats to the owning cache, and buffers one DCache write so writebacks overlap with refills. Sits between both caches and the bus bridge inside the CPU top.

## Interface
- ADDR_W, 32, address width
- LINE_OFF_W, 4, line-offset bits (16-byte line); the read-after-write check compares addr[ADDR_W-1:LINE_OFF_W]
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- ic_rd_req / ic_rd_type[3] / ic_rd_addr[32]  input  ICache read request, held until ic_rd_rdy
- ic_rd_rdy  output  1  ICache request accepted (one-cycle pulse)
- ic_ret_valid / ic_ret_last  output  1 each  beat for ICache; ic_ret_data  output  32
- dc_rd_req / dc_rd_type[3] / dc_rd_addr[32]  input  DCache read request; dc_rd_rdy  output  1
- dc_ret_valid / dc_ret_last  output  1 each; dc_ret_data  output  32
- dc_wr_req / dc_wr_type[3] / dc_wr_addr[32] / dc_wr_wstrb[4] / dc_wr_data[128]  input  DCache write
- dc_wr_rdy  output  1  write buffer empty; write accepted when dc_wr_req && dc_wr_rdy
- rd_req / rd_type[3] / rd_addr[32]  output  bus read request; rd_rdy  input  1
- ret_valid / ret_last  input  1 each; ret_data  input  32
- wr_req / wr_type[3] / wr_addr[32] / wr_wstrb[4] / wr_data[128]  output  bus write; wr_rdy  input  1
- arb_busy  output  1  read FSM not in R_IDLE or write buffer valid

## Operation
- Read FSM: R_IDLE, R_REQ, R_DATA. Owner register own_dc (0 = ICache, 1 = DCache).
- R_IDLE: choose among eligible requesters. ICache is eligible when ic_rd_req = 1. DCache is eligible when dc_rd_req = 1 and there is no RAW hit. A RAW hit is wbuf_valid with matching line address.
- R_IDLE on a win: the winner's rd_rdy pulses combinationally in the same cycle. Type and addr are latched, own_dc is set, and the FSM moves to R_REQ.
- R_REQ: rd_req = 1 with the latched type/addr. Moves to R_DATA on the edge where rd_rdy = 1.
- R_DATA: ret_valid/ret_last/ret_data are routed combinationally to the owner's ret_* ports. The non-owner's ret_valid stays 0. Returns to R_IDLE on ret_valid && ret_last.
- ret_valid outside R_DATA is ignored.
- Write buffer: one entry (wbuf_valid plus latched type/addr/wstrb/data). dc_wr_rdy = !wbuf_valid.
- Write accept: the entry is loaded on dc_wr_req && dc_wr_rdy.
- Write drain: bus wr_req = wbuf_valid with the latched fields. wbuf_valid clears on the edge where wr_req && wr_rdy.
- No load and drain in the same cycle.
- The write path runs independently of the read FSM, so a read and a write may be outstanding together.
- ICache reads are never RAW-checked; code coherence is handled by ibar/cacop.

## Timing
- Reset values: all outputs 0, including the rd_rdy pulses, rd_req, wr_req and arb_busy. dc_wr_rdy = 1 after reset. FSM in R_IDLE, wbuf_valid = 0, rr_last = 0.
- Cache request in cycle 0 with the FSM idle: cache rd_rdy in cycle 0, bus rd_req from cycle 1.
- With bus rd_rdy high immediately, the first return beat can be forwarded from cycle 2.
- Return data is forwarded combinationally (zero latency). Back-to-back reads need at least 1 cycle in R_IDLE after ret_last.
- Write accepted in cycle 0: bus wr_req from cycle 1 until wr_rdy. dc_wr_rdy goes high the cycle after the wr_rdy edge.
- RAW block: a DCache read to the buffered line stalls, with no dc_rd_rdy, until wbuf_valid clears. It can be granted in the first cycle wbuf_valid = 0.
- Async reset mid-transfer: all state clears immediately and outputs return to reset values. The bus bridge must be reset together with this block.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin between ICache and DCache reads. A 1-bit rr_last records the last winner. When both are eligible, the one that did not win last is granted.
- Not defined: fixed priority, DCache over ICache; rr_last is not implemented.

## Test plan
- ICache only: ic_rd_req, type 3'b100, addr 0x1C000000. Expect ic_rd_rdy in cycle 0 and rd_req/rd_addr = 0x1C000000 in cycle 1. 4 beats 0x11..0x44 appear on ic_ret_data, with ic_ret_last on beat 4 and dc_ret_valid = 0 throughout.
- Simultaneous reads, ic addr 0x1000 and dc addr 0x2000:
  - Fixed priority: dc wins; ic is granted after dc's ret_last.
  - With ARB_ROUND_ROBIN_EN: repeating the same pair alternates winners dc, ic, dc, ic.
- Write then RAW read: write to 0x00800010 with wr_rdy held low 10 cycles, then dc read of 0x0080001C. Expect no dc_rd_rdy until the wr_rdy edge, then a grant in the next cycle.
- Overlap: dc write to 0x3000 and ic read to 0x4000 in the same cycle. Expect wr_req and rd_req both high in cycle 1, each completing independently.
- Write buffer full: a second dc_wr_req while wbuf_valid gets dc_wr_rdy = 0 until the first write drains; the second write's data then appears on wr_data unchanged.
- Reset during R_DATA after beat 2: assert reset low. rd_req, ret routing and arb_busy go to 0 immediately. After release, a new ic request is granted normally.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// Shares the cache-to-bus read/write port between ICache and DCache: one outstanding read, one buffered write.
// Optional ARB_ROUND_ROBIN_EN selects round-robin read arbitration instead of fixed DCache priority.
`timescale 1ns/1ps
module cache_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_OFF_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_rd_req_i,
  input  logic [2:0]        ic_rd_type_i,
  input  logic [ADDR_W-1:0] ic_rd_addr_i,
  output logic              ic_rd_rdy_o,
  output logic              ic_ret_valid_o,
  output logic              ic_ret_last_o,
  output logic [31:0]       ic_ret_data_o,
  input  logic              dc_rd_req_i,
  input  logic [2:0]        dc_rd_type_i,
  input  logic [ADDR_W-1:0] dc_rd_addr_i,
  output logic              dc_rd_rdy_o,
  output logic              dc_ret_valid_o,
  output logic              dc_ret_last_o,
  output logic [31:0]       dc_ret_data_o,
  input  logic              dc_wr_req_i,
  input  logic [2:0]        dc_wr_type_i,
  input  logic [ADDR_W-1:0] dc_wr_addr_i,
  input  logic [3:0]        dc_wr_wstrb_i,
  input  logic [127:0]      dc_wr_data_i,
  output logic              dc_wr_rdy_o,
  output logic              rd_req_o,
  output logic [2:0]        rd_type_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_rdy_i,
  input  logic              ret_valid_i,
  input  logic              ret_last_i,
  input  logic [31:0]       ret_data_i,
  output logic              wr_req_o,
  output logic [2:0]        wr_type_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [3:0]        wr_wstrb_o,
  output logic [127:0]      wr_data_o,
  input  logic              wr_rdy_i,
  output logic              arb_busy_o
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_e;

  rd_state_e         state_q, state_d;
  logic              own_dc_q, own_dc_d;
  logic [2:0]        rd_type_q, rd_type_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              wbuf_valid_q, wbuf_valid_d;
  logic [2:0]        wbuf_type_q, wbuf_type_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [3:0]        wbuf_wstrb_q, wbuf_wstrb_d;
  logic [127:0]      wbuf_data_q, wbuf_data_d;

  logic raw_hit, ic_elig, dc_elig, grant_dc, grant_ic;

  // A DCache read may not bypass a buffered write to the same line.
  assign raw_hit = wbuf_valid_q &&
                   (dc_rd_addr_i[ADDR_W-1:LINE_OFF_W] == wbuf_addr_q[ADDR_W-1:LINE_OFF_W]);
  assign ic_elig = ic_rd_req_i;
  assign dc_elig = dc_rd_req_i && !raw_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;

  // rr_last_q = 1 means DCache won the previous arbitration.
  assign grant_dc = dc_elig && (!ic_elig || !rr_last_q);

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == R_IDLE && (grant_dc || grant_ic)) rr_last_d = grant_dc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= 1'b0;
    else        rr_last_q <= rr_last_d;
  end
`else
  assign grant_dc = dc_elig;
`endif
  assign grant_ic = ic_elig && !grant_dc;

  // Read FSM next-state, grant pulses and return-beat routing.
  always_comb begin
    state_d        = state_q;
    own_dc_d       = own_dc_q;
    rd_type_d      = rd_type_q;
    rd_addr_d      = rd_addr_q;
    ic_rd_rdy_o    = 1'b0;
    dc_rd_rdy_o    = 1'b0;
    rd_req_o       = 1'b0;
    ic_ret_valid_o = 1'b0;
    ic_ret_last_o  = 1'b0;
    ic_ret_data_o  = '0;
    dc_ret_valid_o = 1'b0;
    dc_ret_last_o  = 1'b0;
    dc_ret_data_o  = '0;
    unique case (state_q)
      R_IDLE: begin
        if (grant_dc) begin
          dc_rd_rdy_o = 1'b1;
          own_dc_d    = 1'b1;
          rd_type_d   = dc_rd_type_i;
          rd_addr_d   = dc_rd_addr_i;
          state_d     = R_REQ;
        end else if (grant_ic) begin
          ic_rd_rdy_o = 1'b1;
          own_dc_d    = 1'b0;
          rd_type_d   = ic_rd_type_i;
          rd_addr_d   = ic_rd_addr_i;
          state_d     = R_REQ;
        end
      end
      R_REQ: begin
        rd_req_o = 1'b1;
        if (rd_rdy_i) state_d = R_DATA;
      end
      R_DATA: begin
        if (own_dc_q) begin
          dc_ret_valid_o = ret_valid_i;
          dc_ret_last_o  = ret_last_i;
          dc_ret_data_o  = ret_data_i;
        end else begin
          ic_ret_valid_o = ret_valid_i;
          ic_ret_last_o  = ret_last_i;
          ic_ret_data_o  = ret_data_i;
        end
        if (ret_valid_i && ret_last_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      own_dc_q  <= 1'b0;
      rd_type_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      own_dc_q  <= own_dc_d;
      rd_type_q <= rd_type_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Single-entry write buffer: load only when empty, drain on bus handshake.
  always_comb begin
    wbuf_valid_d = wbuf_valid_q;
    wbuf_type_d  = wbuf_type_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_wstrb_d = wbuf_wstrb_q;
    wbuf_data_d  = wbuf_data_q;
    if (!wbuf_valid_q) begin
      if (dc_wr_req_i) begin
        wbuf_valid_d = 1'b1;
        wbuf_type_d  = dc_wr_type_i;
        wbuf_addr_d  = dc_wr_addr_i;
        wbuf_wstrb_d = dc_wr_wstrb_i;
        wbuf_data_d  = dc_wr_data_i;
      end
    end else if (wr_rdy_i) begin
      wbuf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_valid_q <= 1'b0;
      wbuf_type_q  <= '0;
      wbuf_addr_q  <= '0;
      wbuf_wstrb_q <= '0;
      wbuf_data_q  <= '0;
    end else begin
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_type_q  <= wbuf_type_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_wstrb_q <= wbuf_wstrb_d;
      wbuf_data_q  <= wbuf_data_d;
    end
  end

  assign rd_type_o   = rd_type_q;
  assign rd_addr_o   = rd_addr_q;
  assign wr_req_o    = wbuf_valid_q;
  assign wr_type_o   = wbuf_type_q;
  assign wr_addr_o   = wbuf_addr_q;
  assign wr_wstrb_o  = wbuf_wstrb_q;
  assign wr_data_o   = wbuf_data_q;
  assign dc_wr_rdy_o = !wbuf_valid_q;
  assign arb_busy_o  = (state_q != R_IDLE) || wbuf_valid_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: transaction-level model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_cache_bus_arbiter;

  localparam int unsigned OFF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ic_rd_req = 0, dc_rd_req = 0, dc_wr_req = 0;
  logic [2:0]   ic_rd_type = 0, dc_rd_type = 0, dc_wr_type = 0;
  logic [31:0]  ic_rd_addr = 0, dc_rd_addr = 0, dc_wr_addr = 0;
  logic [3:0]   dc_wr_wstrb = 0;
  logic [127:0] dc_wr_data = 0;
  logic         rd_rdy = 0, ret_valid = 0, ret_last = 0, wr_rdy = 0;
  logic [31:0]  ret_data = 0;

  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0]  ic_ret_data, dc_ret_data, rd_addr, wr_addr;
  logic         dc_wr_rdy, rd_req, wr_req, arb_busy;
  logic [2:0]   rd_type, wr_type;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;

  cache_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_req_i(ic_rd_req), .ic_rd_type_i(ic_rd_type), .ic_rd_addr_i(ic_rd_addr),
    .ic_rd_rdy_o(ic_rd_rdy), .ic_ret_valid_o(ic_ret_valid), .ic_ret_last_o(ic_ret_last),
    .ic_ret_data_o(ic_ret_data),
    .dc_rd_req_i(dc_rd_req), .dc_rd_type_i(dc_rd_type), .dc_rd_addr_i(dc_rd_addr),
    .dc_rd_rdy_o(dc_rd_rdy), .dc_ret_valid_o(dc_ret_valid), .dc_ret_last_o(dc_ret_last),
    .dc_ret_data_o(dc_ret_data),
    .dc_wr_req_i(dc_wr_req), .dc_wr_type_i(dc_wr_type), .dc_wr_addr_i(dc_wr_addr),
    .dc_wr_wstrb_i(dc_wr_wstrb), .dc_wr_data_i(dc_wr_data), .dc_wr_rdy_o(dc_wr_rdy),
    .rd_req_o(rd_req), .rd_type_o(rd_type), .rd_addr_o(rd_addr), .rd_rdy_i(rd_rdy),
    .ret_valid_i(ret_valid), .ret_last_i(ret_last), .ret_data_i(ret_data),
    .wr_req_o(wr_req), .wr_type_o(wr_type), .wr_addr_o(wr_addr), .wr_wstrb_o(wr_wstrb),
    .wr_data_o(wr_data), .wr_rdy_i(wr_rdy), .arb_busy_o(arb_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } wr_t;

  wr_t         wq[$];
  wr_t         m_w;
  int          ph = 0;        // 0 no read, 1 waiting bus accept, 2 receiving beats
  bit          m_own_dc = 0;
  bit          m_last_dc = 0; // who won the previous arbitration
  logic [31:0] m_addr = 0;
  logic [2:0]  m_type = 0;
  bit          m_dc_ok, m_win_dc, m_win_ic, m_pref_dc;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; m_own_dc = 0; m_last_dc = 0; m_addr = 0; m_type = 0;
      wq.delete();
      chk("rst ic_rd_rdy", 128'(ic_rd_rdy), 128'(0));
      chk("rst dc_rd_rdy", 128'(dc_rd_rdy), 128'(0));
      chk("rst rd_req", 128'(rd_req), 128'(0));
      chk("rst rd_addr", 128'(rd_addr), 128'(0));
      chk("rst wr_req", 128'(wr_req), 128'(0));
      chk("rst wr_data", wr_data, 128'(0));
      chk("rst ic_ret_valid", 128'(ic_ret_valid), 128'(0));
      chk("rst dc_ret_valid", 128'(dc_ret_valid), 128'(0));
      chk("rst dc_wr_rdy", 128'(dc_wr_rdy), 128'(1));
      chk("rst arb_busy", 128'(arb_busy), 128'(0));
    end else begin
      m_dc_ok = dc_rd_req &&
                !(wq.size() > 0 && (dc_rd_addr >> OFF) == (wq[0].a >> OFF));
`ifdef ARB_ROUND_ROBIN_EN
      m_pref_dc = !m_last_dc;
`else
      m_pref_dc = 1'b1;
`endif
      m_win_dc = (ph == 0) && m_dc_ok && (!ic_rd_req || m_pref_dc);
      m_win_ic = (ph == 0) && ic_rd_req && !m_win_dc;

      chk("m ic_rd_rdy", 128'(ic_rd_rdy), 128'(m_win_ic));
      chk("m dc_rd_rdy", 128'(dc_rd_rdy), 128'(m_win_dc));
      chk("m rd_req", 128'(rd_req), 128'(ph == 1));
      if (ph == 1) begin
        chk("m rd_addr", 128'(rd_addr), 128'(m_addr));
        chk("m rd_type", 128'(rd_type), 128'(m_type));
      end
      chk("m ic_ret_valid", 128'(ic_ret_valid), 128'(ph == 2 && !m_own_dc && ret_valid));
      chk("m dc_ret_valid", 128'(dc_ret_valid), 128'(ph == 2 && m_own_dc && ret_valid));
      if (ph == 2 && ret_valid) begin
        if (m_own_dc) begin
          chk("m dc_ret_data", 128'(dc_ret_data), 128'(ret_data));
          chk("m dc_ret_last", 128'(dc_ret_last), 128'(ret_last));
        end else begin
          chk("m ic_ret_data", 128'(ic_ret_data), 128'(ret_data));
          chk("m ic_ret_last", 128'(ic_ret_last), 128'(ret_last));
        end
      end
      chk("m wr_req", 128'(wr_req), 128'(wq.size() > 0));
      chk("m dc_wr_rdy", 128'(dc_wr_rdy), 128'(wq.size() == 0));
      if (wq.size() > 0) begin
        chk("m wr_addr", 128'(wr_addr), 128'(wq[0].a));
        chk("m wr_type", 128'(wr_type), 128'(wq[0].t));
        chk("m wr_wstrb", 128'(wr_wstrb), 128'(wq[0].s));
        chk("m wr_data", wr_data, wq[0].d);
      end
      chk("m arb_busy", 128'(arb_busy), 128'(ph != 0 || wq.size() > 0));

      // advance to the state after the coming clock edge
      if (m_win_dc || m_win_ic) begin
        m_own_dc  = m_win_dc;
        m_last_dc = m_win_dc;
        m_addr    = m_win_dc ? dc_rd_addr : ic_rd_addr;
        m_type    = m_win_dc ? dc_rd_type : ic_rd_type;
        ph = 1;
      end else if (ph == 1 && rd_rdy) begin
        ph = 2;
      end else if (ph == 2 && ret_valid && ret_last) begin
        ph = 0;
      end
      if (wq.size() == 0) begin
        if (dc_wr_req) begin
          m_w = '{t: dc_wr_type, a: dc_wr_addr, s: dc_wr_wstrb, d: dc_wr_data};
          wq.push_back(m_w);
        end
      end else if (wr_rdy) begin
        void'(wq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in the cycle after a grant: accepts the request and returns 4 beats.
  task automatic serve_read(input logic [31:0] ea, input bit edc, input logic [31:0] base);
    settle();
    chk("lit rd_req", 128'(rd_req), 128'(1));
    chk("lit rd_addr", 128'(rd_addr), 128'(ea));
    rd_rdy = 1;
    step();
    rd_rdy = 0;
    for (int b = 0; b < 4; b++) begin
      ret_valid = 1;
      ret_last  = (b == 3);
      ret_data  = base | (32'(b + 1) * 32'h11);
      settle();
      if (edc) begin
        chk("lit dc_ret_valid", 128'(dc_ret_valid), 128'(1));
        chk("lit dc_ret_data", 128'(dc_ret_data), 128'(base | (32'(b + 1) * 32'h11)));
        chk("lit ic_ret_valid", 128'(ic_ret_valid), 128'(0));
      end else begin
        chk("lit ic_ret_valid", 128'(ic_ret_valid), 128'(1));
        chk("lit ic_ret_data", 128'(ic_ret_data), 128'(base | (32'(b + 1) * 32'h11)));
        chk("lit dc_ret_valid", 128'(dc_ret_valid), 128'(0));
      end
      step();
    end
    ret_valid = 0; ret_last = 0; ret_data = 0;
  endtask

  bit exp_dc;

  initial begin
    step(); step();
    rst_n = 1;
    step();

    // ICache only
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C000000;
    settle();
    chk("lit t1 ic_rd_rdy", 128'(ic_rd_rdy), 128'(1));
    step();
    ic_rd_req = 0;
    chk("lit t1 rd_type", 128'(rd_type), 128'(3'b100));
    serve_read(32'h1C000000, 1'b0, 32'h0);

    // Contention with ICache held: DCache first, ICache right after ret_last
    ic_rd_req = 1; ic_rd_addr = 32'h1000;
    dc_rd_req = 1; dc_rd_addr = 32'h2000; dc_rd_type = 3'b100;
    settle();
    chk("lit t2 dc_rd_rdy", 128'(dc_rd_rdy), 128'(1));
    chk("lit t2 ic_rd_rdy", 128'(ic_rd_rdy), 128'(0));
    step();
    dc_rd_req = 0;
    serve_read(32'h2000, 1'b1, 32'h100);
    settle();
    chk("lit t2 ic after", 128'(ic_rd_rdy), 128'(1));
    step();
    ic_rd_req = 0;
    serve_read(32'h1000, 1'b0, 32'h200);

    // Repeated pair: fixed priority always DCache, round-robin alternates
    for (int r = 0; r < 4; r++) begin
      ic_rd_req = 1; dc_rd_req = 1;
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      exp_dc = (r % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      chk("lit rr dc_rd_rdy", 128'(dc_rd_rdy), 128'(exp_dc));
      chk("lit rr ic_rd_rdy", 128'(ic_rd_rdy), 128'(!exp_dc));
      step();
      ic_rd_req = 0; dc_rd_req = 0;
      serve_read(exp_dc ? 32'h2000 : 32'h1000, exp_dc, 32'h300);
    end

    // Write, then RAW read of the same line
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h00800010;
    dc_wr_wstrb = 4'hF; dc_wr_data = 128'h0123456789ABCDEF_FEDCBA9876543210;
    settle();
    chk("lit t3 dc_wr_rdy", 128'(dc_wr_rdy), 128'(1));
    step();
    dc_wr_req = 0;
    dc_rd_req = 1; dc_rd_addr = 32'h0080001C;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("lit t3 wr_req", 128'(wr_req), 128'(1));
      chk("lit t3 raw stall", 128'(dc_rd_rdy), 128'(0));
      step();
    end
    wr_rdy = 1;
    settle();
    chk("lit t3 wr_addr", 128'(wr_addr), 128'(32'h00800010));
    chk("lit t3 stall at edge", 128'(dc_rd_rdy), 128'(0));
    step();
    wr_rdy = 0;
    settle();
    chk("lit t3 grant", 128'(dc_rd_rdy), 128'(1));
    chk("lit t3 wr_rdy back", 128'(dc_wr_rdy), 128'(1));
    step();
    dc_rd_req = 0;
    serve_read(32'h0080001C, 1'b1, 32'h400);

    // Overlapping write and ICache read
    dc_wr_req = 1; dc_wr_addr = 32'h3000; dc_wr_data = 128'hAAAA;
    ic_rd_req = 1; ic_rd_addr = 32'h4000;
    settle();
    chk("lit t4 ic_rd_rdy", 128'(ic_rd_rdy), 128'(1));
    step();
    dc_wr_req = 0; ic_rd_req = 0;
    chk("lit t4 wr_req", 128'(wr_req), 128'(1));
    chk("lit t4 rd_req", 128'(rd_req), 128'(1));
    wr_rdy = 1;
    serve_read(32'h4000, 1'b0, 32'h500);
    wr_rdy = 0;

    // Write buffer full
    dc_wr_req = 1; dc_wr_addr = 32'h5000; dc_wr_wstrb = 4'hF; dc_wr_data = 128'h1111;
    step();
    dc_wr_addr = 32'h6000; dc_wr_wstrb = 4'h3; dc_wr_type = 3'b001;
    dc_wr_data = 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("lit t5 full", 128'(dc_wr_rdy), 128'(0));
      chk("lit t5 first addr", 128'(wr_addr), 128'(32'h5000));
      step();
    end
    wr_rdy = 1;
    step();
    wr_rdy = 0;
    settle();
    chk("lit t5 rdy again", 128'(dc_wr_rdy), 128'(1));
    step();
    dc_wr_req = 0;
    chk("lit t5 wr_addr", 128'(wr_addr), 128'(32'h6000));
    chk("lit t5 wr_wstrb", 128'(wr_wstrb), 128'(4'h3));
    chk("lit t5 wr_data", wr_data, 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE);
    wr_rdy = 1;
    step();
    wr_rdy = 0;

    // Reset during R_DATA after beat 2
    ic_rd_req = 1; ic_rd_addr = 32'h7000;
    step();
    ic_rd_req = 0; rd_rdy = 1;
    step();
    rd_rdy = 0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1; ret_last = 0; ret_data = 32'h70 + 32'(b);
      step();
    end
    ret_data = 32'h72;
    settle();
    chk("lit t6 busy pre", 128'(arb_busy), 128'(1));
    chk("lit t6 beat3 pre", 128'(ic_ret_valid), 128'(1));
    rst_n = 0;
    settle();
    chk("lit t6 ret cut", 128'(ic_ret_valid), 128'(0));
    chk("lit t6 rd_req", 128'(rd_req), 128'(0));
    chk("lit t6 busy", 128'(arb_busy), 128'(0));
    step();
    ret_valid = 0; ret_data = 0;
    step();
    rst_n = 1;
    step();
    ic_rd_req = 1; ic_rd_addr = 32'h8000;
    settle();
    chk("lit t6 regrant", 128'(ic_rd_rdy), 128'(1));
    step();
    ic_rd_req = 0;
    serve_read(32'h8000, 1'b0, 32'h800);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
